utility_pulse_stretch: RTL and testbench

Converts single-cycle strobes, such as those produced by the team's positive-edge pulse generator, back into a clean level of fixed width. The output is high for a programmable hold time and is followed by an enforced minimum low gap. Requests that arrive while the output is high or in the gap are queued to a depth of one; any further requests are counted as drops. The block sits on the far side of clock-domain-local edge detection and drives slow consumers such as LEDs, external enables and handshake lines that need a minimum pulse width.

---
 rtl/utility_pkg.sv | 31 +++
 rtl/utility_down_counter.sv | 35 +++
 rtl/utility_pulse_stretch.sv | 155 +++++++++++++++
 tb/tb_utility_pulse_stretch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utility_pkg.sv
//------------------------------------------------------------------------------
// Module  : utility_pkg
// Purpose : Shared state encoding and constant-width helper for utility blocks.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package utility_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Bits needed to represent values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/utility_down_counter.sv
//------------------------------------------------------------------------------
// Module  : utility_down_counter
// Purpose : Loadable down-counter that parks at zero and flags it.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module utility_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/utility_pulse_stretch.sv
//------------------------------------------------------------------------------
// Module  : utility_pulse_stretch
// Purpose : Stretches strobes to HOLD_CYCLES high with a GAP_CYCLES low gap;
//           one request queued, extras counted. Macro
//           UTILITY_PULSE_STRETCH_RETRIG_EN makes requests during HOLD extend it.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module utility_pulse_stretch
    import utility_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic             out,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int c_MAXC  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W = clog2(c_MAXC + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  =
        (GAP_CYCLES > 0) ? c_CNT_W'(GAP_CYCLES - 1) : '0;

    state_t             r_state;
    logic               r_pending;
    logic               r_out;
    logic               r_busy;
    logic [CNT_W-1:0]   r_drop;

    state_t             w_nstate;
    logic               w_npend;
    logic               w_drop;
    logic               w_load;
    logic               w_en;
    logic [c_CNT_W-1:0] w_load_val;
    logic               w_zero;

    utility_down_counter #(
        .WIDTH (c_CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_en),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_nstate   = r_state;
        w_npend    = r_pending;
        w_drop     = 1'b0;
        w_load     = 1'b0;
        w_en       = 1'b0;
        w_load_val = c_HOLD_LOAD;
        case (r_state)
            ST_IDLE: begin
                if (in) begin
                    w_nstate = ST_HOLD;
                    w_load   = 1'b1;
                end
            end
            ST_HOLD: begin
                w_en = 1'b1;
`ifdef UTILITY_PULSE_STRETCH_RETRIG_EN
                if (in) begin
                    w_load = 1'b1;
                end else if (w_zero) begin
                    if (GAP_CYCLES > 0) begin
                        w_nstate   = ST_GAP;
                        w_load     = 1'b1;
                        w_load_val = c_GAP_LOAD;
                    end else if (r_pending) begin
                        w_load  = 1'b1;
                        w_npend = 1'b0;
                    end else begin
                        w_nstate = ST_IDLE;
                    end
                end
`else
                // With no gap, a last-cycle request merges with the pending one.
                if (w_zero && (GAP_CYCLES == 0)) begin
                    if (r_pending || in) begin
                        w_load  = 1'b1;
                        w_npend = r_pending && in;
                    end else begin
                        w_nstate = ST_IDLE;
                    end
                end else begin
                    if (in) begin
                        if (r_pending) w_drop  = 1'b1;
                        else           w_npend = 1'b1;
                    end
                    if (w_zero) begin
                        w_nstate   = ST_GAP;
                        w_load     = 1'b1;
                        w_load_val = c_GAP_LOAD;
                    end
                end
`endif
            end
            ST_GAP: begin
                w_en = 1'b1;
                if (w_zero) begin
                    if (r_pending || in) begin
                        w_nstate = ST_HOLD;
                        w_load   = 1'b1;
                        w_npend  = r_pending && in;
                    end else begin
                        w_nstate = ST_IDLE;
                    end
                end else if (in) begin
                    if (r_pending) w_drop  = 1'b1;
                    else           w_npend = 1'b1;
                end
            end
            default: begin
                w_nstate = ST_IDLE;
                w_npend  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_out     <= 1'b0;
            r_busy    <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_state   <= w_nstate;
            r_pending <= w_npend;
            r_out     <= (w_nstate == ST_HOLD);
            r_busy    <= (w_nstate != ST_IDLE) || w_npend;
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign out      = r_out;
    assign busy     = r_busy;
    assign drop_cnt = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_utility_pulse_stretch.sv
//------------------------------------------------------------------------------
// Module  : tb_utility_pulse_stretch
// Purpose : Self-checking bench for utility_pulse_stretch (HOLD=16, GAP=4).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_utility_pulse_stretch;

    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int CW   = 8;
`ifdef UTILITY_PULSE_STRETCH_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in  = 1'b0;
    logic          out;
    logic          busy;
    logic [CW-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference: remaining high cycles, remaining gap cycles, queued request.
    int m_hi   = 0;
    int m_lo   = 0;
    bit m_q    = 1'b0;
    int m_drop = 0;

    always #5 clk = ~clk;

    utility_pulse_stretch #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .CNT_W       (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .out      (out),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    task automatic model_accept(input bit req);
        if (req) begin
            if (m_q) m_drop++;
            else     m_q = 1'b1;
        end
    endtask

    task automatic model_step(input bit req);
        if (m_hi > 0) begin
            if (RETRIG && req) begin
                m_hi = HOLD;
            end else begin
                m_hi--;
                if (m_hi == 0 && GAP == 0) begin
                    if (m_q || req) begin
                        m_hi = HOLD;
                        m_q  = m_q && req;
                    end
                end else begin
                    model_accept(req);
                    if (m_hi == 0) m_lo = GAP;
                end
            end
        end else if (m_lo > 0) begin
            m_lo--;
            if (m_lo == 0) begin
                if (m_q || req) begin
                    m_hi = HOLD;
                    m_q  = m_q && req;
                end
            end else begin
                model_accept(req);
            end
        end else if (req) begin
            m_hi = HOLD;
        end
    endtask

    function automatic logic exp_out();
        return m_hi > 0;
    endfunction

    function automatic logic exp_busy();
        return (m_hi > 0) || (m_lo > 0) || m_q;
    endfunction

    function automatic logic [CW-1:0] exp_drop();
        return (m_drop > 255) ? 8'hFF : CW'(m_drop);
    endfunction

    // One clock: drive inputs, advance the model, settle past the edge.
    task automatic tick(input bit r, input bit req);
        rst = r;
        in  = req;
        @(posedge clk);
        if (r) begin
            m_hi = 0; m_lo = 0; m_q = 1'b0; m_drop = 0;
        end else begin
            model_step(req);
        end
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        total++;
        if (out !== 1'b0 || busy !== 1'b0 || drop_cnt !== '0) begin
            bad++;
            $display("FAIL reset: out=%b busy=%b drop=%0d required 0/0/0", out, busy, drop_cnt);
        end
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        total++;
        if (out !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: out=%b busy=%b required 0/0", out, busy);
        end
    endtask

    task automatic test_single();
        logic eo, eb;
        do_reset();
        for (int t = 0; t < 30; t++) begin
            tick(1'b0, t == 0);
            eo = (t + 1 >= 1) && (t + 1 <= HOLD);
            eb = (t + 1 <= HOLD + GAP);
            total++;
            if (out !== eo || busy !== eb) begin
                bad++;
                $display("FAIL single s=%0d: out=%b busy=%b required %b/%b", t + 1, out, busy, eo, eb);
            end
        end
        total++;
        if (drop_cnt !== '0) begin
            bad++;
            $display("FAIL single_drop: drop=%0d required 0", drop_cnt);
        end
    endtask

    task automatic test_two();
        logic eo;
        int   s;
        do_reset();
        for (int t = 0; t < 45; t++) begin
            tick(1'b0, (t == 0) || (t == 5));
            s  = t + 1;
            eo = RETRIG ? (s <= 21) : ((s <= 16) || (s >= 21 && s <= 36));
            total++;
            if (out !== eo) begin
                bad++;
                $display("FAIL two s=%0d: out=%b required %b", s, out, eo);
            end
        end
        total++;
        if (drop_cnt !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL two_end: drop=%0d busy=%b required 0/0", drop_cnt, busy);
        end
    endtask

    task automatic test_three();
        logic          eo;
        logic [CW-1:0] ed;
        int            s;
        do_reset();
        for (int t = 0; t < 45; t++) begin
            tick(1'b0, (t == 0) || (t == 2) || (t == 4));
            s  = t + 1;
            eo = RETRIG ? (s <= 20) : ((s <= 16) || (s >= 21 && s <= 36));
            ed = (!RETRIG && s >= 5) ? 8'd1 : 8'd0;
            total++;
            if (out !== eo || drop_cnt !== ed) begin
                bad++;
                $display("FAIL three s=%0d: out=%b drop=%0d required %b/%0d", s, out, drop_cnt, eo, ed);
            end
        end
    endtask

    task automatic test_retrig();
        logic eo;
        int   s;
        do_reset();
        for (int t = 0; t < 42; t++) begin
            tick(1'b0, (t == 0) || (t == 10));
            s  = t + 1;
            eo = RETRIG ? (s <= 26) : ((s <= 16) || (s >= 21 && s <= 36));
            total++;
            if (out !== eo || drop_cnt !== '0) begin
                bad++;
                $display("FAIL retrig s=%0d: out=%b drop=%0d required %b/0", s, out, drop_cnt, eo);
            end
        end
    endtask

    task automatic test_saturate();
        logic [CW-1:0] ed;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            tick(1'b0, 1'b1);
            total++;
            if (out !== exp_out() || busy !== exp_busy() || drop_cnt !== exp_drop()) begin
                bad++;
                $display("FAIL sat t=%0d: out=%b busy=%b drop=%0d required %b/%b/%0d",
                         t, out, busy, drop_cnt, exp_out(), exp_busy(), exp_drop());
            end
        end
        ed = RETRIG ? 8'd0 : 8'd255;
        for (int t = 0; t < 20; t++) tick(1'b0, 1'b1);
        total++;
        if (drop_cnt !== ed) begin
            bad++;
            $display("FAIL sat_final: drop=%0d required %0d", drop_cnt, ed);
        end
    endtask

    task automatic test_reset_mid();
        int highs;
        do_reset();
        for (int t = 0; t < 8; t++) tick(1'b0, t == 0 || t == 3 || t == 5);
        tick(1'b1, 1'b0);
        total++;
        if (out !== 1'b0 || busy !== 1'b0 || drop_cnt !== '0) begin
            bad++;
            $display("FAIL reset_mid: out=%b busy=%b drop=%0d required 0/0/0", out, busy, drop_cnt);
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        highs = 0;
        while (out === 1'b1 && highs < 40) begin
            highs++;
            tick(1'b0, 1'b0);
        end
        total++;
        if (highs != HOLD) begin
            bad++;
            $display("FAIL reset_restart: high_cycles=%0d required %0d", highs, HOLD);
        end
    endtask

    task automatic test_random();
        bit r, q;
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            r = ($urandom_range(0, 299) == 0);
            q = ($urandom_range(0, 5) == 0) || (t % 300 > 250);
            tick(r, q);
            total++;
            if (out !== exp_out() || busy !== exp_busy() || drop_cnt !== exp_drop()) begin
                bad++;
                $display("FAIL random t=%0d: out=%b busy=%b drop=%0d required %b/%b/%0d",
                         t, out, busy, drop_cnt, exp_out(), exp_busy(), exp_drop());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_three();
        test_retrig();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
